rv32i_mc_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core. Sequences the shared register file, ALU, immediate extender and a single unified instruction/data memory port over several cycles per instruction. Decodes the latched instruction word and uses the ALU flags to drive every datapath enable and mux select. Holds in any memory state until the memory handshake completes.

---
 rtl/rv32i_mc_controller.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rv32i_mc_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_controller.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch, decode and
// execute over a shared ALU and a single unified memory port.
module rv32i_mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_code,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    input  logic        V,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        pc_we,
    output logic        old_pc_we,
    output logic        ir_we,
    output logic        RegWrite,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [4:0]  ALUControl,
    output logic        retire,
    output logic        illegal
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd10;

    localparam logic [1:0] SRC_A_RS1   = 2'd0;
    localparam logic [1:0] SRC_A_PC    = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;
    localparam logic [1:0] SRC_B_RS2   = 2'd0;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;
    localparam logic [1:0] SRC_B_FOUR  = 2'd2;
    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MDR     = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    state_t     state_r;
    state_t     state_next_s;
    logic       illegal_r;
    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7b5_s;
    logic       unused_s;

    assign opcode_s   = instruction_code[6:0];
    assign funct3_s   = instruction_code[14:12];
    assign funct7b5_s = instruction_code[30];
    assign unused_s   = ^{instruction_code[31], instruction_code[29:15], instruction_code[11:7]};

    // alt selects SUB/SRA; the caller decides when funct7[30] is meaningful
    function automatic logic [4:0] alu_op_f(input logic [2:0] funct3, input logic alt);
        logic [4:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken_f(input logic [2:0] funct3,
                                            input logic n, input logic z,
                                            input logic c, input logic v);
        logic taken;
        case (funct3)
            3'b000:  taken = z;
            3'b001:  taken = !z;
            3'b100:  taken = n ^ v;
            3'b101:  taken = !(n ^ v);
            3'b110:  taken = !c;
            3'b111:  taken = c;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Next-state and datapath control decode; everything is held at 0 during reset
    always_comb begin
        state_next_s = state_r;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src      = 1'b0;
        pc_we        = 1'b0;
        old_pc_we    = 1'b0;
        ir_we        = 1'b0;
        RegWrite     = 1'b0;
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        result_src   = RES_ALUOUT;
        ALUControl   = ALU_ADD;
        retire       = 1'b0;
        if (rst) begin
            state_next_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRC_A_PC;
                    alu_src_b  = SRC_B_FOUR;
                    result_src = RES_ALU;
                    if (mem_ready) begin
                        ir_we        = 1'b1;
                        pc_we        = 1'b1;
                        old_pc_we    = 1'b1;
                        state_next_s = S_DECODE;
                    end else begin
                        state_next_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    case (opcode_s)
                        OP_R:      state_next_s = S_EXEC_R;
                        OP_I:      state_next_s = S_EXEC_I;
                        OP_LOAD:   state_next_s = S_MEM_ADDR;
                        OP_STORE:  state_next_s = S_MEM_ADDR;
                        OP_BRANCH: state_next_s = S_BRANCH;
                        OP_JAL:    state_next_s = S_JAL;
                        OP_JALR:   state_next_s = S_JALR;
                        OP_LUI:    state_next_s = S_LUI;
                        OP_AUIPC:  state_next_s = S_AUIPC;
                        default:   state_next_s = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    ALUControl   = alu_op_f(funct3_s, funct7b5_s);
                    state_next_s = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_b    = SRC_B_IMM;
                    ALUControl   = alu_op_f(funct3_s, funct7b5_s && (funct3_s == 3'b101));
                    state_next_s = S_ALU_WB;
                end
                S_MEM_ADDR: begin
                    alu_src_b = SRC_B_IMM;
                    if (opcode_s[5]) begin
                        state_next_s = S_MEM_WR;
                    end else begin
                        state_next_s = S_MEM_RD;
                    end
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        state_next_s = S_MEM_WB;
                    end else begin
                        state_next_s = S_MEM_RD;
                    end
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        retire       = 1'b1;
                        state_next_s = S_FETCH;
                    end else begin
                        state_next_s = S_MEM_WR;
                    end
                end
                S_MEM_WB: begin
                    RegWrite     = 1'b1;
                    result_src   = RES_MDR;
                    retire       = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_ALU_WB: begin
                    RegWrite     = 1'b1;
                    retire       = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_BRANCH: begin
                    ALUControl = ALU_SUB;
                    // funct3 010/011 have no branch meaning and end in TRAP
                    if ((funct3_s == 3'b010) || (funct3_s == 3'b011)) begin
                        state_next_s = S_TRAP;
                    end else begin
                        pc_we        = branch_taken_f(funct3_s, N, Z, C, V);
                        retire       = 1'b1;
                        state_next_s = S_FETCH;
                    end
                end
                S_JAL: begin
                    pc_we        = 1'b1;
                    alu_src_a    = SRC_A_OLDPC;
                    alu_src_b    = SRC_B_FOUR;
                    state_next_s = S_ALU_WB;
                end
                S_JALR: begin
                    pc_we        = 1'b1;
                    alu_src_b    = SRC_B_IMM;
                    result_src   = RES_ALU;
                    state_next_s = S_LINK;
                end
                S_LINK: begin
                    alu_src_a    = SRC_A_OLDPC;
                    alu_src_b    = SRC_B_FOUR;
                    state_next_s = S_ALU_WB;
                end
                S_LUI: begin
                    alu_src_b    = SRC_B_IMM;
                    ALUControl   = ALU_PASS_B;
                    state_next_s = S_ALU_WB;
                end
                S_AUIPC: begin
                    alu_src_a    = SRC_A_OLDPC;
                    alu_src_b    = SRC_B_IMM;
                    state_next_s = S_ALU_WB;
                end
                S_TRAP: begin
                    state_next_s = S_TRAP;
                end
                default: begin
                    state_next_s = S_FETCH;
                end
            endcase
        end
    end

    // State register and sticky illegal-instruction flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s == S_TRAP) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    assign illegal = illegal_r && !rst;

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Randomized bench for rv32i_mc_controller: a per-instruction cycle model
// built from the instruction-class rules is compared with the DUT every cycle.
module tb_rv32i_mc_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction_code = 32'd0;
    logic        N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, pc_we, old_pc_we, ir_we, RegWrite;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [4:0]  ALUControl;
    logic        retire, illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rv32i_mc_controller dut (
        .clk(clk), .rst(rst), .instruction_code(instruction_code),
        .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .pc_we(pc_we),
        .old_pc_we(old_pc_we), .ir_we(ir_we), .RegWrite(RegWrite),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .ALUControl(ALUControl), .retire(retire), .illegal(illegal)
    );

    logic [19:0] obs_s;
    assign obs_s = {mem_req, mem_we, adr_src, pc_we, old_pc_we, ir_we, RegWrite,
                    alu_src_a, alu_src_b, result_src, ALUControl, retire, illegal};

    logic [19:0] exp_q[$];
    bit          rdy_q[$];
    logic [4:0]  f3_op [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected output vector, same field order as obs_s
    function automatic logic [19:0] vec(input int mreq, input int mwe, input int adr,
                                        input int pcw, input int opcw, input int irw,
                                        input int rw, input int sa, input int sb,
                                        input int rs, input int alu, input int ret,
                                        input int ill);
        return {mreq[0], mwe[0], adr[0], pcw[0], opcw[0], irw[0], rw[0],
                sa[1:0], sb[1:0], rs[1:0], alu[4:0], ret[0], ill[0]};
    endfunction

    // mode 0/1 drives mem_ready to that value, 2 drives a random value
    task automatic push(input logic [19:0] v, input int mode);
        exp_q.push_back(v);
        if (mode == 2) rdy_q.push_back(1'($urandom % 2));
        else           rdy_q.push_back(mode[0]);
    endtask

    function automatic logic [4:0] ref_alu(input logic [2:0] f3, input logic alt);
        logic [4:0] op = f3_op[f3];
        if (alt && f3 == 3'd0) op = 5'd1;
        if (alt && f3 == 3'd5) op = 5'd7;
        return op;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    task automatic m_fetch(input int w);
        for (int i = 0; i < w; i++) push(vec(1,0,0,0,0,0,0, 1,2,2, 0,0,0), 0);
        push(vec(1,0,0,1,1,1,0, 1,2,2, 0,0,0), 1);
        push(vec(0,0,0,0,0,0,0, 2,1,0, 0,0,0), 2);
    endtask

    task automatic m_writeback();
        push(vec(0,0,0,0,0,0,1, 0,0,0, 0,1,0), 2);
    endtask

    // Builds the cycle-by-cycle expectation of one instruction
    task automatic model_instr(input logic [31:0] ins, input bit taken, input int wf,
                               input int wm, output bit trapped, output int exp_ret);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic       f7 = ins[30];
        trapped = 1'b0;
        exp_ret = 1;
        m_fetch(wf);
        case (op)
            7'b0110011: begin push(vec(0,0,0,0,0,0,0, 0,0,0, int'(ref_alu(f3, f7)),0,0), 2); m_writeback(); end
            7'b0010011: begin push(vec(0,0,0,0,0,0,0, 0,1,0, int'(ref_alu(f3, f7 && f3 == 3'd5)),0,0), 2); m_writeback(); end
            7'b0000011: begin
                push(vec(0,0,0,0,0,0,0, 0,1,0, 0,0,0), 2);
                for (int i = 0; i < wm; i++) push(vec(1,0,1,0,0,0,0, 0,0,0, 0,0,0), 0);
                push(vec(1,0,1,0,0,0,0, 0,0,0, 0,0,0), 1);
                push(vec(0,0,0,0,0,0,1, 0,0,1, 0,1,0), 2);
            end
            7'b0100011: begin
                push(vec(0,0,0,0,0,0,0, 0,1,0, 0,0,0), 2);
                for (int i = 0; i < wm; i++) push(vec(1,1,1,0,0,0,0, 0,0,0, 0,0,0), 0);
                push(vec(1,1,1,0,0,0,0, 0,0,0, 0,1,0), 1);
            end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    push(vec(0,0,0,0,0,0,0, 0,0,0, 1,0,0), 2);
                    trapped = 1'b1;
                    exp_ret = 0;
                end else begin
                    push(vec(0,0,0,int'(taken),0,0,0, 0,0,0, 1,1,0), 2);
                end
            end
            7'b1101111: begin push(vec(0,0,0,1,0,0,0, 2,2,0, 0,0,0), 2); m_writeback(); end
            7'b1100111: begin
                push(vec(0,0,0,1,0,0,0, 0,1,2, 0,0,0), 2);
                push(vec(0,0,0,0,0,0,0, 2,2,0, 0,0,0), 2);
                m_writeback();
            end
            7'b0110111: begin push(vec(0,0,0,0,0,0,0, 0,1,0, 10,0,0), 2); m_writeback(); end
            7'b0010111: begin push(vec(0,0,0,0,0,0,0, 2,1,0, 0,0,0), 2); m_writeback(); end
            default: begin trapped = 1'b1; exp_ret = 0; end
        endcase
    endtask

    task automatic run_queue(input string tag, input logic [31:0] code,
                             input logic [3:0] flags, output int ret_seen);
        logic [19:0] v;
        bit r;
        ret_seen = 0;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            r = rdy_q.pop_front();
            @(negedge clk);
            rst              = 1'b0;
            instruction_code = code;
            {N, Z, C, V}     = flags;
            mem_ready        = r;
            #1;
            check_eq(tag, 32'(obs_s), 32'(v));
            if (retire === 1'b1) ret_seen++;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'($urandom % 2);
        #1;
        check_eq(tag, 32'(obs_s), 32'd0);
    endtask

    // Flags come from the operands as the ALU would produce them for a - b
    task automatic do_instr(input string tag, input logic [31:0] code, input logic [31:0] a,
                            input logic [31:0] b, input int wf, input int wm);
        logic [31:0] d = a - b;
        logic [3:0]  flags;
        bit          taken, trapped;
        int          exp_ret, ret_seen;
        flags = {d[31], (d == 32'd0), (a >= b), (a[31] != b[31]) && (d[31] != a[31])};
        case (code[14:12])
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = ($signed(a) <  $signed(b));
            3'd5:    taken = ($signed(a) >= $signed(b));
            3'd6:    taken = (a <  b);
            default: taken = (a >= b);
        endcase
        model_instr(code, taken, wf, wm, trapped, exp_ret);
        if (trapped) begin
            for (int i = 0; i < 10; i++) push(vec(0,0,0,0,0,0,0, 0,0,0, 0,0,1), 2);
        end
        run_queue(tag, code, flags, ret_seen);
        check_eq({tag, "_retire"}, 32'(ret_seen), 32'(exp_ret));
        if (trapped) do_reset({tag, "_rst"});
    endtask

    initial begin
        logic [31:0] code, a, b;
        int ret_seen, cls;
        logic [6:0] op;
        logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        rst = 1'b1;
        @(negedge clk); #1; check_eq("reset0", 32'(obs_s), 32'd0);
        @(negedge clk); #1; check_eq("reset1", 32'(obs_s), 32'd0);

        do_instr("add",  {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'd1, 32'd2, 0, 0);
        do_instr("lw3",  {12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011}, 32'd0, 32'd0, 0, 3);
        do_instr("beq_t",  {7'd0, 5'd2, 5'd1, 3'b000, 5'd4, 7'b1100011}, 32'd7, 32'd7, 0, 0);
        do_instr("beq_nt", {7'd0, 5'd2, 5'd1, 3'b000, 5'd4, 7'b1100011}, 32'd7, 32'd9, 0, 0);
        do_instr("bltu_c0", {7'd0, 5'd2, 5'd1, 3'b110, 5'd4, 7'b1100011}, 32'd3, 32'hFFFF_0000, 0, 0);
        do_instr("bgeu_c0", {7'd0, 5'd2, 5'd1, 3'b111, 5'd4, 7'b1100011}, 32'd3, 32'hFFFF_0000, 0, 0);
        do_instr("srai", {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd2, 7'b0010011}, 32'd0, 32'd0, 1, 0);
        do_instr("srli", {7'b0000000, 5'd3, 5'd1, 3'b101, 5'd2, 7'b0010011}, 32'd0, 32'd0, 0, 0);
        do_instr("addi_b30", {12'h400, 5'd1, 3'b000, 5'd2, 7'b0010011}, 32'd0, 32'd0, 0, 0);
        do_instr("illegal0", 32'd0, 32'd0, 32'd0, 0, 0);

        code = {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011};
        m_fetch(0);
        push(vec(0,0,0,0,0,0,0, 0,1,0, 0,0,0), 2);
        push(vec(1,1,1,0,0,0,0, 0,0,0, 0,0,0), 0);
        push(vec(1,1,1,0,0,0,0, 0,0,0, 0,0,0), 0);
        run_queue("sw_wait", code, 4'd0, ret_seen);
        check_eq("sw_wait_retire", 32'(ret_seen), 32'd0);
        do_reset("rst_memwr");
        do_instr("sw_after_rst", code, 32'd0, 32'd0, 0, 1);

        for (int n = 0; n < 250; n++) begin
            cls  = int'($urandom % 10);
            code = $urandom;
            if (cls < 9) begin
                op = ops[cls];
            end else begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end
            code[6:0] = op;
            a = $urandom;
            b = ($urandom % 4 == 0) ? a : $urandom;
            do_instr($sformatf("rand%0d", n), code, a, b, int'($urandom % 3), int'($urandom % 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
